// File: rtl/snum_entry_pkg.sv
// Shared definitions for the decimal entry front-end: FSM encoding and
// decimal constants.
package snum_entry_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  localparam int         DEC_BASE  = 10;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

endpackage

// File: rtl/snum_entry_btn_edge.sv
// Button conditioner: synchronizer chain followed by a rising-edge detector
// producing a one-cycle press pulse.
module btn_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   prev_q, prev_d;
  logic                   armed_q, armed_d;
  logic                   sync_out;

  // fill_q marks when sync_out carries a real post-reset sample; the detector
  // only arms after it has seen the button released, so a button held through
  // reset cannot fire on release of reset.
  always_comb begin
    sync_d   = SYNC_STAGES'({sync_q, raw_in});
    fill_d   = SYNC_STAGES'({fill_q, 1'b1});
    sync_out = sync_q[SYNC_STAGES-1];
    prev_d   = sync_out;
    armed_d  = armed_q | (fill_q[SYNC_STAGES-1] & ~sync_out);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      fill_q  <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      fill_q  <= fill_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

  assign press = armed_q & sync_out & ~prev_q;

endmodule

// File: rtl/snum_entry.sv
// Decimal entry front-end: builds a sign-magnitude number from button presses.
//   state     | meaning
//   ST_EMPTY  | no digits yet, sign may be toggled
//   ST_ENTRY  | digits being accepted
//   ST_COMMIT | one cycle after commit, live value is cleared
module snum_entry
  import snum_entry_pkg::*;
#(
  parameter int MAX_DIGITS  = 3,
  parameter int MAX_MAG     = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit,
  input  logic       digit_btn,
  input  logic       sign_btn,
  input  logic       clear_btn,
  input  logic       commit_btn,
  output logic [7:0] live_mag,
  output logic       live_neg,
  output logic [7:0] mag,
  output logic       neg,
  output logic       valid,
  output logic       err,
  output logic [1:0] count
);

  localparam logic [1:0] MAX_CNT   = 2'(MAX_DIGITS);
  localparam logic [9:0] MAX_MAG_W = 10'(MAX_MAG);

  logic digit_ev, sign_ev, clear_ev, commit_ev;

  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_digit (
    .clk(clk), .rst_n(rst_n), .raw_in(digit_btn), .press(digit_ev));
  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sign (
    .clk(clk), .rst_n(rst_n), .raw_in(sign_btn), .press(sign_ev));
  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clear (
    .clk(clk), .rst_n(rst_n), .raw_in(clear_btn), .press(clear_ev));
  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_commit (
    .clk(clk), .rst_n(rst_n), .raw_in(commit_btn), .press(commit_ev));

  state_e     state_q, state_d;
  logic [7:0] live_mag_q, live_mag_d;
  logic       live_neg_q, live_neg_d;
  logic [7:0] mag_q, mag_d;
  logic       neg_q, neg_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic [1:0] count_q, count_d;
  logic [9:0] cand;
  logic       dig_ok;

  always_comb begin
    cand   = {2'b00, live_mag_q} * 10'(DEC_BASE) + {6'b0, digit};
    dig_ok = (digit <= DIGIT_MAX) && (count_q != MAX_CNT) && (cand <= MAX_MAG_W);

    state_d    = state_q;
    live_mag_d = live_mag_q;
    live_neg_d = live_neg_q;
    mag_d      = mag_q;
    neg_d      = neg_q;
    count_d    = count_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_COMMIT: begin
        live_mag_d = '0;
        live_neg_d = 1'b0;
        count_d    = '0;
        state_d    = ST_EMPTY;
      end
      default: begin
        // Priority: clear > commit > digit > sign; losers are dropped.
        if (clear_ev) begin
          live_mag_d = '0;
          live_neg_d = 1'b0;
          count_d    = '0;
          state_d    = ST_EMPTY;
        end else if (commit_ev) begin
          mag_d   = live_mag_q;
          neg_d   = live_neg_q & (|live_mag_q);
          valid_d = 1'b1;
          state_d = ST_COMMIT;
        end else if (digit_ev) begin
          if (dig_ok) begin
            live_mag_d = cand[7:0];
            count_d    = count_q + 2'd1;
            state_d    = ST_ENTRY;
          end else begin
            err_d = 1'b1;
          end
        end else if (sign_ev) begin
          live_neg_d = ~live_neg_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      live_mag_q <= '0;
      live_neg_q <= 1'b0;
      mag_q      <= '0;
      neg_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      live_mag_q <= live_mag_d;
      live_neg_q <= live_neg_d;
      mag_q      <= mag_d;
      neg_q      <= neg_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      count_q    <= count_d;
    end
  end

  assign live_mag = live_mag_q;
  assign live_neg = live_neg_q;
  assign mag      = mag_q;
  assign neg      = neg_q;
  assign valid    = valid_q;
  assign err      = err_q;
  assign count    = count_q;

endmodule
